// File: rtl/display_pkg.sv
// Shared display timing defaults, layer word layout and counter widths
// for the sprite display path.
package display_pkg;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;
    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;
    localparam int DEF_PIPE_LAT = 3;
    localparam bit DEF_SYNC_POL = 1'b0;

    localparam int RGB_W   = 24;
    localparam int LAYER_W = 25;
    localparam int OPAQUE  = 0;
    localparam int COL_W   = 12;
    localparam int ROW_W   = 11;
    localparam int FCNT_W  = 16;

    localparam logic [RGB_W-1:0] DEF_BG_COLOR = 24'h000000;

    // Layer colour word: {rgb, opaque}, opaque in bit OPAQUE (LSB)
    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic             opaque;
    } layer_t;
endpackage

// File: rtl/frame_scanner_if.sv
// Scanner <-> layers/display bus: scan coordinates out, layer colours in,
// composited video and frame status out.
interface frame_scanner_if;
    import display_pkg::*;

    logic [COL_W-1:0]   display_col;
    logic [ROW_W-1:0]   display_row;
    logic               calc;
    logic [LAYER_W-1:0] enemy_color;
    logic [LAYER_W-1:0] player_color;
    logic [LAYER_W-1:0] bullet_color;
    logic               hit;
    logic [RGB_W-1:0]   rgb;
    logic               hsync;
    logic               vsync;
    logic               blank;
    logic               frame_start;
    logic [FCNT_W-1:0]  frame_count;

    modport master (
        output display_col, display_row, calc, hit, rgb, hsync, vsync,
               blank, frame_start, frame_count,
        input  enemy_color, player_color, bullet_color
    );

    modport slave (
        input  display_col, display_row, calc, hit, rgb, hsync, vsync,
               blank, frame_start, frame_count,
        output enemy_color, player_color, bullet_color
    );
endinterface

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with async active-low clear; lines up the
// scan timing terms with the layer colour returns.
module pipe_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/frame_scanner.sv
// Display scan generator and sprite-layer compositor: scan counters, calc
// window, sync timing, priority composite and enemy/bullet hit pulse.
module frame_scanner
    import display_pkg::*;
#(
    parameter int               H_ACTIVE = DEF_H_ACTIVE,
    parameter int               H_FP     = DEF_H_FP,
    parameter int               H_SYNC   = DEF_H_SYNC,
    parameter int               H_BP     = DEF_H_BP,
    parameter int               V_ACTIVE = DEF_V_ACTIVE,
    parameter int               V_FP     = DEF_V_FP,
    parameter int               V_SYNC   = DEF_V_SYNC,
    parameter int               V_BP     = DEF_V_BP,
    parameter int               PIPE_LAT = DEF_PIPE_LAT,
    parameter bit               SYNC_POL = DEF_SYNC_POL,
    parameter logic [RGB_W-1:0] BG_COLOR = DEF_BG_COLOR
) (
    input  logic            clock,
    input  logic            reset,
    frame_scanner_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_CALC = ROW_W'(V_ACTIVE);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_bad_timing
            $error("frame_scanner: H_TOTAL must be <= 4096 and V_TOTAL <= 2048");
        end
    endgenerate

    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic              line_end, frame_end;
    logic              calc_q, frame_start_q;
    logic [FCNT_W-1:0] frame_count_q;

    always_comb begin
        line_end  = (col == COL_LAST);
        frame_end = line_end && (row == ROW_LAST);
        col_nxt   = line_end ? '0 : col + COL_W'(1);
        row_nxt   = row;
        if (frame_end)     row_nxt = '0;
        else if (line_end) row_nxt = row + ROW_W'(1);
    end

    // calc follows the next-cycle row so it changes together with display_row
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col           <= '0;
            row           <= '0;
            calc_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            col           <= col_nxt;
            row           <= row_nxt;
            calc_q        <= (row_nxt >= ROW_CALC);
            frame_start_q <= frame_end;
            if (frame_end) frame_count_q <= frame_count_q + FCNT_W'(1);
        end
    end

    logic       vis, hs_raw, vs_raw;
    logic [2:0] term_d;
    logic       vis_d, hs_d, vs_d;

    always_comb begin
        vis    = (int'(col) < H_ACTIVE) && (int'(row) < V_ACTIVE);
        hs_raw = (int'(col) >= H_ACTIVE + H_FP) && (int'(col) < H_ACTIVE + H_FP + H_SYNC);
        vs_raw = (int'(row) >= V_ACTIVE + V_FP) && (int'(row) < V_ACTIVE + V_FP + V_SYNC);
    end

    pipe_delay #(.WIDTH(3), .DEPTH(PIPE_LAT)) u_align (
        .clock (clock),
        .reset (reset),
        .d     ({vis, hs_raw, vs_raw}),
        .q     (term_d)
    );

    assign vis_d = term_d[2];
    assign hs_d  = term_d[1];
    assign vs_d  = term_d[0];

    layer_t           enemy, player, bullet;
    logic [RGB_W-1:0] pix;

    assign enemy  = layer_t'(bus.enemy_color);
    assign player = layer_t'(bus.player_color);
    assign bullet = layer_t'(bus.bullet_color);

    // Lowest priority first so later assignments win
    always_comb begin
        pix = BG_COLOR;
        if (bullet.opaque) pix = bullet.rgb;
        if (enemy.opaque)  pix = enemy.rgb;
        if (player.opaque) pix = player.rgb;
    end

    logic [RGB_W-1:0] rgb_q;
    logic             hit_q, blank_q, hsync_q, vsync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_q   <= '0;
            hit_q   <= 1'b0;
            blank_q <= 1'b1;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else begin
            rgb_q   <= vis_d ? pix : '0;
            hit_q   <= vis_d & enemy.opaque & bullet.opaque;
            blank_q <= ~vis_d;
            hsync_q <= hs_d ^ ~SYNC_POL;
            vsync_q <= vs_d ^ ~SYNC_POL;
        end
    end

    assign bus.display_col = col;
    assign bus.display_row = row;
    assign bus.calc        = calc_q;
    assign bus.hit         = hit_q;
    assign bus.rgb         = rgb_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.blank       = blank_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: a default-timing instance and a shrunken-timing
// instance checked every cycle against an arithmetic scan model.
module tb_frame_scanner;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   kcnt;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    frame_scanner_if bus ();
    frame_scanner_if bus_s ();

    assign bus_s.enemy_color  = bus.enemy_color;
    assign bus_s.player_color = bus.player_color;
    assign bus_s.bullet_color = bus.bullet_color;

    frame_scanner dut (.clock(clock), .reset(reset), .bus(bus));

    frame_scanner #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (.clock(clock), .reset(reset), .bus(bus_s));

    typedef struct {
        int ha, hfp, hsw, ht;
        int va, vfp, vsw, vt;
    } tim_t;

    localparam tim_t T_DEF = '{ha:1280, hfp:48, hsw:112, ht:1688, va:1024, vfp:1, vsw:3, vt:1066};
    localparam tim_t T_SM  = '{ha:8, hfp:2, hsw:3, ht:16, va:6, vfp:1, vsw:2, vt:10};
    localparam int   LAT   = 4;

    // posedges since the last reset release
    always @(posedge clock or negedge reset)
        if (!reset) kcnt <= 0;
        else        kcnt <= kcnt + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h exp=%0h t=%0t", nm, kcnt, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] prio(input logic [24:0] pe, input logic [24:0] pp,
                                         input logic [24:0] pb);
        if (pp[0]) return pp[24:1];
        if (pe[0]) return pe[24:1];
        if (pb[0]) return pb[24:1];
        return 24'h000000;
    endfunction

    task automatic model_chk(input string tag, input tim_t t, input int k,
                             input logic [24:0] pe, input logic [24:0] pp, input logic [24:0] pb,
                             input logic [11:0] col, input logic [10:0] row, input logic calc,
                             input logic hit, input logic [23:0] rgb, input logic hs,
                             input logic vs, input logic blank, input logic fs,
                             input logic [15:0] fc);
        int  frame, ec, er, m, cm, rm;
        bit  vis, hsr, vsr;
        frame = t.ht * t.vt;
        ec    = k % t.ht;
        er    = (k / t.ht) % t.vt;
        m     = k - LAT;
        vis = 0; hsr = 0; vsr = 0;
        if (m >= 0) begin
            cm  = m % t.ht;
            rm  = (m / t.ht) % t.vt;
            vis = (cm < t.ha) && (rm < t.va);
            hsr = (cm >= t.ha + t.hfp) && (cm < t.ha + t.hfp + t.hsw);
            vsr = (rm >= t.va + t.vfp) && (rm < t.va + t.vfp + t.vsw);
        end
        chk({tag, ".col"},   32'(col),   32'(ec));
        chk({tag, ".row"},   32'(row),   32'(er));
        chk({tag, ".calc"},  32'(calc),  32'(er >= t.va));
        chk({tag, ".fs"},    32'(fs),    32'(k > 0 && k % frame == 0));
        chk({tag, ".fc"},    32'(fc),    32'((k / frame) % 65536));
        chk({tag, ".rgb"},   32'(rgb),   vis ? 32'(prio(pe, pp, pb)) : 32'h0);
        chk({tag, ".hit"},   32'(hit),   32'(vis & pe[0] & pb[0]));
        chk({tag, ".blank"}, 32'(blank), 32'(!vis));
        chk({tag, ".hsync"}, 32'(hs),    32'(!hsr));
        chk({tag, ".vsync"}, 32'(vs),    32'(!vsr));
    endtask

    // colour words applied during the previous cycle, i.e. those the composite just captured
    logic [24:0] prv_e = '0, prv_p = '0, prv_b = '0;

    always @(negedge clock) begin
        model_chk("def", T_DEF, kcnt, prv_e, prv_p, prv_b,
                  bus.display_col, bus.display_row, bus.calc, bus.hit, bus.rgb,
                  bus.hsync, bus.vsync, bus.blank, bus.frame_start, bus.frame_count);
        model_chk("sm", T_SM, kcnt, prv_e, prv_p, prv_b,
                  bus_s.display_col, bus_s.display_row, bus_s.calc, bus_s.hit, bus_s.rgb,
                  bus_s.hsync, bus_s.vsync, bus_s.blank, bus_s.frame_start, bus_s.frame_count);
        prv_e <= bus.enemy_color;
        prv_p <= bus.player_color;
        prv_b <= bus.bullet_color;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_k(input int k);
        for (int n = 0; n < 10000 && kcnt < k; n++) step();
        if (kcnt < k) chk("wait_k_timeout", 32'(kcnt), 32'(k));
    endtask

    task automatic set_col(input logic [24:0] e, input logic [24:0] p, input logic [24:0] b);
        bus.enemy_color  = e;
        bus.player_color = p;
        bus.bullet_color = b;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".col"},   32'(bus.display_col), 32'h0);
        chk({tag, ".row"},   32'(bus.display_row), 32'h0);
        chk({tag, ".calc"},  32'(bus.calc),        32'h0);
        chk({tag, ".hit"},   32'(bus.hit),         32'h0);
        chk({tag, ".rgb"},   32'(bus.rgb),         32'h0);
        chk({tag, ".blank"}, 32'(bus.blank),       32'h1);
        chk({tag, ".hsync"}, 32'(bus.hsync),       32'h1);
        chk({tag, ".vsync"}, 32'(bus.vsync),       32'h1);
        chk({tag, ".fs"},    32'(bus.frame_start), 32'h0);
        chk({tag, ".fc"},    32'(bus.frame_count), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog k=%0d", kcnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_col('0, '0, '0);
        reset = 1'b0;
        repeat (5) step();
        chk_reset_vals("rst");
        reset = 1'b1;

        // priority composite on row 0 pixels 10..13 (inputs driven LAT-1 clocks after the coordinate)
        wait_k(13); set_col({24'h00FF00, 1'b1}, {24'hFF0000, 1'b1}, '0);
        wait_k(14); set_col({24'h00FF00, 1'b1}, '0, '0);
        chk("lit.p_over_e", 32'(bus.rgb), 32'hFF0000);
        chk("lit.p_hit",    32'(bus.hit), 32'h0);
        wait_k(15); set_col('0, {24'hFFFFFF, 1'b0}, {24'h0000FF, 1'b1});
        chk("lit.enemy",    32'(bus.rgb), 32'h00FF00);
        wait_k(16); set_col({24'h123456, 1'b0}, {24'hFFFFFF, 1'b0}, {24'hABCDEF, 1'b0});
        chk("lit.bullet",   32'(bus.rgb), 32'h0000FF);
        wait_k(17); set_col('0, '0, '0);
        chk("lit.bg",       32'(bus.rgb), 32'h000000);
        chk("lit.bg_blank", 32'(bus.blank), 32'h0);

        // three adjacent overlapping pixels 20..22
        wait_k(23); set_col({24'h00FF00, 1'b1}, '0, {24'h0000FF, 1'b1});
        chk("lit.hit_pre", 32'(bus.hit), 32'h0);
        wait_k(24);
        chk("lit.hit0",    32'(bus.hit), 32'h1);
        chk("lit.hit_rgb", 32'(bus.rgb), 32'h00FF00);
        wait_k(26); set_col('0, '0, '0);
        chk("lit.hit2",    32'(bus.hit), 32'h1);
        wait_k(27);
        chk("lit.hit_end", 32'(bus.hit), 32'h0);

        // shrunken instance: calc edge and frame wrap
        wait_k(95);
        chk("lit.s_calc_lo", 32'(bus_s.calc), 32'h0);
        wait_k(96);
        chk("lit.s_calc_hi", 32'(bus_s.calc), 32'h1);
        chk("lit.s_row6",    32'(bus_s.display_row), 32'd6);
        wait_k(160);
        chk("lit.s_fs",      32'(bus_s.frame_start), 32'h1);
        chk("lit.s_fc",      32'(bus_s.frame_count), 32'h1);
        chk("lit.s_calc_wr", 32'(bus_s.calc), 32'h0);
        wait_k(161);
        chk("lit.s_fs_pulse", 32'(bus_s.frame_start), 32'h0);

        // overlap during horizontal blanking must not hit
        wait_k(1293); set_col({24'h00FF00, 1'b1}, '0, {24'h0000FF, 1'b1});
        wait_k(1294);
        chk("lit.blank_hit",  32'(bus.hit), 32'h0);
        chk("lit.blank_rgb",  32'(bus.rgb), 32'h0);
        chk("lit.blank_flag", 32'(bus.blank), 32'h1);
        wait_k(1296); set_col('0, '0, '0);

        // hsync window: col 1328..1439 shows up LAT clocks later
        wait_k(1331); chk("lit.hs_pre",   32'(bus.hsync), 32'h1);
        wait_k(1332); chk("lit.hs_first", 32'(bus.hsync), 32'h0);
        wait_k(1443); chk("lit.hs_last",  32'(bus.hsync), 32'h0);
        wait_k(1444); chk("lit.hs_post",  32'(bus.hsync), 32'h1);
        wait_k(1687);
        chk("lit.col_last", 32'(bus.display_col), 32'd1687);
        chk("lit.row0",     32'(bus.display_row), 32'd0);
        wait_k(1688);
        chk("lit.col_wrap", 32'(bus.display_col), 32'd0);
        chk("lit.row1",     32'(bus.display_row), 32'd1);

        // reset mid-frame at (700,1) with overlap stimulus running
        wait_k(2380); set_col({24'h00FF00, 1'b1}, '0, {24'h0000FF, 1'b1});
        wait_k(2388);
        chk("lit.pre_rst_col", 32'(bus.display_col), 32'd700);
        chk("lit.pre_rst_hit", 32'(bus.hit), 32'h1);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) step();
        reset = 1'b1;
        wait_k(1);
        chk("lit.rel_col", 32'(bus.display_col), 32'd1);
        chk("lit.rel_hit", 32'(bus.hit), 32'h0);
        wait_k(3);
        chk("lit.rel_hit3", 32'(bus.hit), 32'h0);
        chk("lit.rel_fs",   32'(bus.frame_start), 32'h0);
        wait_k(4);
        chk("lit.rel_hit4", 32'(bus.hit), 32'h1);
        set_col('0, '0, '0);
        wait_k(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
